// File: rtl/gf12_1rw_sram.sv
// Single-port 256-word synchronous SRAM model (gf12_1rw_256x{32,64,128}) with registered read data.
// Optional macro GF12_SRAM_WRITE_THROUGH_EN makes a write cycle also load q with d.
module gf12_1rw_sram #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_WORDS  = 256,
    parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen,
    input  logic                  gwen,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    // Only the three macro configurations exist in the library.
    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64 || DATA_WIDTH == 128)) begin : g_bad_width
        $error("gf12_1rw_sram: DATA_WIDTH must be 32, 64 or 128");
    end
    if (NUM_WORDS != 256 || ADDR_WIDTH != 8) begin : g_bad_depth
        $error("gf12_1rw_sram: only the 256-word configuration exists");
    end

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
    logic                  wr_en;
    logic                  rd_en;

    assign wr_en = ~rst & ~cen & gwen;
    assign rd_en = ~cen & ~gwen;

    // Array is never reset so contents survive a reset pulse; rst blocks writes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[a] <= d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (rd_en) begin
            q <= mem[a];
        end else if (!cen) begin
`ifdef GF12_SRAM_WRITE_THROUGH_EN
            q <= d;
`else
            q <= q;
`endif
        end
    end

endmodule

// File: tb/tb_gf12_1rw_sram.sv
// Randomized self-checking bench for gf12_1rw_sram: 32/64/128-bit instances share one stimulus stream
// and are compared each cycle against an array-based reference model.
module tb_gf12_1rw_sram;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cen = 1'b1;
    logic         gwen = 1'b0;
    logic [7:0]   a = '0;
    logic [127:0] d = '0;
    logic [31:0]  q32;
    logic [63:0]  q64;
    logic [127:0] q128;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    logic [127:0] ref_mem [256];
    logic [127:0] ref_q;

    always #5 clk = ~clk;

    gf12_1rw_sram #(.DATA_WIDTH(32)) u_dut32 (
        .clk (clk), .rst (rst), .cen (cen), .gwen (gwen), .a (a), .d (d[31:0]), .q (q32)
    );
    gf12_1rw_sram #(.DATA_WIDTH(64)) u_dut64 (
        .clk (clk), .rst (rst), .cen (cen), .gwen (gwen), .a (a), .d (d[63:0]), .q (q64)
    );
    gf12_1rw_sram #(.DATA_WIDTH(128)) u_dut128 (
        .clk (clk), .rst (rst), .cen (cen), .gwen (gwen), .a (a), .d (d), .q (q128)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "/w32"}, {96'd0, q32}, {96'd0, ref_q[31:0]});
        chk({tag, "/w64"}, {64'd0, q64}, {64'd0, ref_q[63:0]});
        chk({tag, "/w128"}, q128, ref_q);
    endtask

    // One access: drive inputs away from the edge, advance the model at the edge, check after it.
    task automatic access(input logic c, input logic g, input logic [7:0] ad,
                          input logic [127:0] dd, input string tag);
        cen  = c;
        gwen = g;
        a    = ad;
        d    = dd;
        @(posedge clk);
        if (!rst && !c) begin
            if (g) begin
                ref_mem[ad] = dd;
`ifdef GF12_SRAM_WRITE_THROUGH_EN
                ref_q = dd;
`endif
            end else begin
                ref_q = ref_mem[ad];
            end
        end
        #1;
        chk_all(tag);
    endtask

    task automatic wr(input logic [7:0] ad, input logic [127:0] dd, input string tag);
        access(1'b0, 1'b1, ad, dd, tag);
    endtask

    task automatic rd(input logic [7:0] ad, input string tag);
        access(1'b0, 1'b0, ad, {$urandom, $urandom, $urandom, $urandom}, tag);
    endtask

    // Asynchronous reset mid-cycle, an attempted write while held, then release.
    task automatic rst_pulse(input logic [7:0] ad, input string tag);
        #2;
        rst = 1'b1;
        ref_q = '0;
        #1;
        chk_all({tag, "/async"});
        access(1'b0, 1'b1, ad, {$urandom, $urandom, $urandom, $urandom}, {tag, "/wr_in_rst"});
        rst = 1'b0;
    endtask

    initial begin
        logic [127:0] rv;
        logic [7:0]   ra;

        // Power-up reset
        #1;
        rst   = 1'b1;
        ref_q = '0;
        #1;
        chk_all("reset");
        access(1'b1, 1'b0, 8'h00, '0, "reset_hold");
        access(1'b0, 1'b1, 8'h00, '1, "reset_wr_ignored");
        rst = 1'b0;

        // Fill every word with its own address, then read all back
        for (int i = 0; i < 256; i++) wr(8'(i), 128'(i), "fill");
        for (int i = 0; i < 256; i++) rd(8'(i), "fill_rb");
        rd(8'h00, "wr_in_rst_not_applied");

        // Write then read, 1-cycle latency
        wr(8'h05, 128'h12345678, "wr05");
        rd(8'h05, "rd05");
        access(1'b1, 1'b0, 8'h05, '0, "rd05_hold");

        // Idle cycles hold q and do not touch the array
        rd(8'hFF, "rdFF");
        for (int i = 0; i < 3; i++)
            access(1'b1, 1'($urandom), 8'($urandom), {$urandom, $urandom, $urandom, $urandom},
                   "idle_hold");
        rd(8'hFF, "rdFF_again");
        for (int i = 0; i < 8; i++) rd(8'($urandom), "idle_array_intact");

        // Wide extremes back to back
        wr(8'h00, '1, "wr00_ones");
        wr(8'hFF, '0, "wrFF_zeros");
        rd(8'h00, "rd00_ones");
        rd(8'hFF, "rdFF_zeros");

        // Contents survive reset; write attempted during reset is dropped
        wr(8'h10, {2{64'hA5A5A5A5A5A5A5A5}}, "wr10");
        rst_pulse(8'h10, "rst10");
        rd(8'h10, "rd10_retained");

        // Async reset clears a known nonzero q
        wr(8'h33, {4{32'hDEADBEEF}}, "wr33");
        rd(8'h33, "rd33");
        rst_pulse(8'h33, "rst33");
        rd(8'h33, "rd33_after_rst");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rv = {$urandom, $urandom, $urandom, $urandom};
            ra = 8'($urandom);
            if ($urandom_range(0, 99) == 0) rst_pulse(ra, "rand_rst");
            else access(1'($urandom_range(0, 3) == 0), 1'($urandom), ra, rv, "rand");
        end
        for (int i = 0; i < 256; i++) rd(8'(i), "final_rb");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gf12_1rw_sram.md
GF12_1RW_SRAM -- requirements
Module: gf12_1rw_sram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128; word width; legal values 32, 64, 128 (the gf12_1rw_256x32/256x64/256x128 configurations).
REQ-002 SHALL have parameter NUM_WORDS, default 256; array depth; fixed at 256.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8; derived as clog2(NUM_WORDS); not to be overridden.
REQ-004 SHALL have port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port: rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port: cen, input, 1, chip enable, active-low (0 = access this cycle).
REQ-007 SHALL have port: gwen, input, 1, global write enable, active-high (1 = write, 0 = read); ignored when cen=1.
REQ-008 SHALL have port: a, input, ADDR_WIDTH, word address.
REQ-009 SHALL have port: d, input, DATA_WIDTH, write data; sampled only on write cycles.
REQ-010 SHALL have port: q, output, DATA_WIDTH, registered read data.

Function
REQ-011 SHALL hold a single-port array of NUM_WORDS x DATA_WIDTH bits.
REQ-012 SHALL write all DATA_WIDTH bits of d to word a on a rising clk edge with cen=0 and gwen=1; there is no byte or bit masking.
REQ-013 SHALL load q with word a on a rising clk edge with cen=0 and gwen=0, so read latency is exactly 1 cycle.
REQ-014 SHALL hold q unchanged when cen=1, regardless of gwen, a and d.
REQ-015 SHALL leave the array unchanged on reads and idle cycles.
REQ-016 SHALL hold q unchanged on write cycles, unless the write-through option (REQ-025) is compiled in.
REQ-017 SHALL return the new data on a read one or more cycles after a write to the same address (no stale data).
REQ-018 SHALL accept back-to-back accesses every cycle with no stall and no handshake; every access completes in one cycle.
REQ-019 SHALL, if a contains X or Z during an access, make a write corrupt no defined word and make a read drive q to all-X in simulation; synthesis behaviour is undefined.
REQ-020 SHALL be a purely synchronous single-port memory: no combinational path from any input to q.

Reset
REQ-021 SHALL force q to all-zeros asynchronously while rst=1, independent of clk.
REQ-022 SHALL NOT clear array contents on reset; contents are preserved across a reset asserted mid-operation.
REQ-023 SHALL ignore any access coinciding with rst=1, including writes to the array.
REQ-024 SHALL, on the first rising clk edge after rst deasserts, perform normal access per REQ-012..REQ-016.

Configuration
REQ-025 SHALL support the macro GF12_SRAM_WRITE_THROUGH_EN: when defined, a write cycle also loads q with d in the same edge; when undefined, q holds its previous value on writes (REQ-016). All other behaviour is identical with and without the macro.

Verification
REQ-026 SHALL cover: rst=1 mid-simulation after q=0xDEADBEEF (DATA_WIDTH=32) -> q=0 immediately without a clk edge.
REQ-027 SHALL cover: write a=0x05 d=0x12345678, then read a=0x05 (DATA_WIDTH=32) -> q=0x12345678 exactly one cycle after the read edge; q unchanged during the write cycle without the macro, and q=0x12345678 at the write edge with the macro.
REQ-028 SHALL cover: read a=0xFF, then hold cen=1 for 3 cycles while toggling a, d and gwen -> q stays at the word-0xFF value, and the array is unchanged (verified by a subsequent readback).
REQ-029 SHALL cover: DATA_WIDTH=128, write a=0x00 with all-ones and a=0xFF with all-zeros, then read both back-to-back -> q shows all-ones then all-zeros on consecutive cycles.
REQ-030 SHALL cover: write a=0x10 d=0xA5A5A5A5A5A5A5A5 (DATA_WIDTH=64), pulse rst, read a=0x10 -> q=0xA5A5A5A5A5A5A5A5 (contents retained).
REQ-031 SHALL cover: DATA_WIDTH=32, write 256 words with value = address, then read all 256 words in sequence -> every read returns its own address, with no aliasing.
